// File: rtl/fwd_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_unit
//   Operand forwarding and latency scoreboard for the CPU pipeline.
//   - EX side: each of NUM_OPS operands picks the nearest forwarding stage that
//     writes a matching non-zero register (combinational).
//   - ID side: each register has a LAT_W down-counter. It is loaded with the
//     producer's extra latency at issue. ID stalls while any operand it reads
//     still has a non-zero counter.
//
// Optional feature macro: FWD_SB_PERF_CNT_EN adds a 32-bit stall_cycles counter.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   ex_rs           EX operand addresses, op k at [k*REG_AW +: REG_AW]
//   fwd_rd/fwd_wr   destination and write enable of each forwarding stage
//                   (index 0 = nearest)
//   fwd_sel         per-operand select: 0 = regfile, j+1 = forwarding source j
//   id_rs/id_rs_used  ID operand addresses and read-enables
//   iss_*           issue of the ID instruction into EX (dest, latency)
//   stall_id        hold ID/IF and insert a bubble
//   sb_busy         per-register counter non-zero (debug)
//   stall_cycles    (FWD_SB_PERF_CNT_EN only) edges with stall_id high
// -----------------------------------------------------------------------------

// Per-operand forwarding select.
module fwdOpSel #(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int SW      = 2
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_wr,
  output logic [SW-1:0]             sel
);
  // Walk farthest to nearest so the lowest matching index is the last writer.
  always_comb begin
    sel = '0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_wr[j] && (fwd_rd[j*REG_AW +: REG_AW] != '0) &&
          (fwd_rd[j*REG_AW +: REG_AW] == rs))
        sel = SW'(j + 1);
    end
  end
endmodule

// Per-register latency counter: load wins over the decrement, saturates at 0.
module fwdSbCnt #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] loadVal,
  output logic [LAT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= loadVal;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end
endmodule

module fwd_scoreboard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_OPS = 2,
  parameter int NUM_FWD = 2,
  parameter int LAT_W   = 3,
  localparam int NUM_REGS = 2**REG_AW,
  localparam int SW       = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_OPS*REG_AW-1:0] ex_rs,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_wr,
  output logic [NUM_OPS*SW-1:0]     fwd_sel,
  input  logic [NUM_OPS*REG_AW-1:0] id_rs,
  input  logic [NUM_OPS-1:0]        id_rs_used,
  input  logic                      iss_valid,
  input  logic                      iss_wr,
  input  logic [REG_AW-1:0]         iss_rd,
  input  logic [LAT_W-1:0]          iss_lat,
  output logic                      stall_id,
  output logic [NUM_REGS-1:0]       sb_busy
`ifdef FWD_SB_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_OPS-1:0]             opStall;
  logic                           issWrite;

  assign issWrite = iss_valid & iss_wr;

  // Forwarding selects, one instance per operand.
  for (genvar k = 0; k < NUM_OPS; k++) begin : gOpSel
    fwdOpSel #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SW(SW)) uSel (
      .rs     (ex_rs[k*REG_AW +: REG_AW]),
      .fwd_rd (fwd_rd),
      .fwd_wr (fwd_wr),
      .sel    (fwd_sel[k*SW +: SW])
    );
  end

  // Scoreboard counters; register 0 is never busy, so it has no counter.
  for (genvar r = 0; r < NUM_REGS; r++) begin : gCnt
    if (r == 0) begin : gZero
      assign cnt[r] = '0;
    end else begin : gReg
      fwdSbCnt #(.LAT_W(LAT_W)) uCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (issWrite && (iss_rd == REG_AW'(r))),
        .loadVal (iss_lat),
        .cnt     (cnt[r])
      );
    end
    assign sb_busy[r] = |cnt[r];
  end

  // ID stall: any read operand whose producer is not yet forwardable.
  // cnt[0] is constant zero, so register 0 can never stall.
  for (genvar k = 0; k < NUM_OPS; k++) begin : gStall
    assign opStall[k] = id_rs_used[k] && sb_busy[id_rs[k*REG_AW +: REG_AW]];
  end

  assign stall_id = |opStall;

`ifdef FWD_SB_PERF_CNT_EN
  // Wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst)           stall_cycles <= '0;
    else if (stall_id) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
module tb_fwd_scoreboard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ex_rs, fwd_rd, id_rs;
  logic [1:0]  fwd_wr, id_rs_used;
  logic [3:0]  fwd_sel;
  logic        iss_valid, iss_wr;
  logic [4:0]  iss_rd;
  logic [2:0]  iss_lat;
  logic        stall_id;
  logic [31:0] sb_busy;
`ifdef FWD_SB_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;
  int mcnt [32];

  always #5 clk = ~clk;

  fwd_scoreboard_unit dut (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .fwd_rd(fwd_rd), .fwd_wr(fwd_wr),
    .fwd_sel(fwd_sel), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .stall_id(stall_id), .sb_busy(sb_busy)
`ifdef FWD_SB_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: each register holds "cycles until forwardable".
  function automatic void mEdge();
    for (int r = 0; r < 32; r++) begin
      if (rst) mcnt[r] = 0;
      else if (r != 0 && iss_valid && iss_wr && int'(iss_rd) == r) mcnt[r] = int'(iss_lat);
      else if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
    end
  endfunction

  function automatic logic mStall();
    logic s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int a = int'(id_rs[k*5 +: 5]);
      if (id_rs_used[k] && a != 0 && mcnt[a] > 0) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] mBusy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (mcnt[r] > 0);
    return b;
  endfunction

  function automatic logic [3:0] mSel();
    logic [3:0] s = '0;
    for (int k = 0; k < 2; k++) begin
      int pick = 0;
      for (int j = 0; j < 2; j++)
        if (pick == 0 && fwd_wr[j] && fwd_rd[j*5 +: 5] != 0 && fwd_rd[j*5 +: 5] == ex_rs[k*5 +: 5])
          pick = j + 1;
      s[k*2 +: 2] = 2'(pick);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    mEdge();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd; iss_lat = lat;
    tick();
    iss_valid = 1'b0; iss_wr = 1'b0;
  endtask

  typedef struct {
    logic [9:0] exRs;
    logic [9:0] fwdRd;
    logic [1:0] fwdWr;
    logic [3:0] expSel;
  } fwdVec_t;

  fwdVec_t vecs [7];

  initial begin
    // {op1,op0}, {rd1,rd0}, wr, {sel1,sel0}
    vecs[0] = '{{5'd0, 5'd3},   {5'd3, 5'd3},   2'b11, 4'h1};
    vecs[1] = '{{5'd0, 5'd3},   {5'd3, 5'd3},   2'b10, 4'h2};
    vecs[2] = '{{5'd0, 5'd0},   {5'd0, 5'd0},   2'b11, 4'h0};
    vecs[3] = '{{5'd6, 5'd4},   {5'd4, 5'd6},   2'b11, 4'h6};
    vecs[4] = '{{5'd5, 5'd5},   {5'd5, 5'd5},   2'b01, 4'h5};
    vecs[5] = '{{5'd8, 5'd8},   {5'd8, 5'd8},   2'b00, 4'h0};
    vecs[6] = '{{5'd31, 5'd31}, {5'd31, 5'd30}, 2'b10, 4'hA};

    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    rst = 1'b1; ex_rs = '0; fwd_rd = '0; fwd_wr = '0; id_rs = '0; id_rs_used = '0;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0; iss_lat = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_stall", 32'(stall_id), 32'd0);
    chk("reset_busy", sb_busy, 32'd0);

    // Forwarding table
    for (int i = 0; i < 7; i++) begin
      ex_rs = vecs[i].exRs; fwd_rd = vecs[i].fwdRd; fwd_wr = vecs[i].fwdWr;
      #1;
      chk($sformatf("fwd_vec%0d", i), 32'(fwd_sel), 32'(vecs[i].expSel));
    end
    ex_rs = '0; fwd_rd = '0; fwd_wr = '0;

    // Load-use: one stall cycle
    issue(5'd5, 3'd1);
    id_rs = {5'd5, 5'd0}; id_rs_used = 2'b10; #1;
    chk("loaduse_stall", 32'(stall_id), 32'd1);
    chk("loaduse_busy", 32'(sb_busy[5]), 32'd1);
    tick();
    chk("loaduse_release", 32'(stall_id), 32'd0);
    chk("loaduse_busy_clr", 32'(sb_busy[5]), 32'd0);

    // Multi-cycle, operand not used: no stall
    id_rs = {5'd0, 5'd7}; id_rs_used = 2'b00;
    issue(5'd7, 3'd4);
    chk("mc_unused_nostall", 32'(stall_id), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    // Multi-cycle, used: exactly 4 stall cycles
    issue(5'd7, 3'd4);
    id_rs_used = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mc_stall%0d", i), 32'(stall_id), 32'd1);
      tick();
    end
    chk("mc_release", 32'(stall_id), 32'd0);
    id_rs_used = 2'b00;

    // WAW override
    issue(5'd9, 3'd5);
    tick(); tick();
    chk("waw_busy_before", 32'(sb_busy[9]), 32'd1);
    issue(5'd9, 3'd1);
    chk("waw_busy_after", 32'(sb_busy[9]), 32'd1);
    tick();
    chk("waw_cleared", 32'(sb_busy[9]), 32'd0);

    // Reset mid-stall
    issue(5'd4, 3'd6);
    tick(); tick(); tick();
    id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01; #1;
    chk("rst_mid_stall_pre", 32'(stall_id), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_stall", 32'(stall_id), 32'd0);
    chk("rst_mid_busy", sb_busy, 32'd0);

    // Register 0 never busy
    id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
    issue(5'd0, 3'd7);
    chk("r0_stall", 32'(stall_id), 32'd0);
    chk("r0_busy", sb_busy, 32'd0);

    // Max latency
    id_rs = {5'd12, 5'd0}; id_rs_used = 2'b10;
    issue(5'd12, 3'd7);
    for (int i = 0; i < 7; i++) tick();
    chk("maxlat_release", 32'(stall_id), 32'd0);

`ifdef FWD_SB_PERF_CNT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf_reset", stall_cycles, 32'd0);
    id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
    issue(5'd4, 3'd6);
    for (int i = 0; i < 8; i++) tick();
    chk("perf_count6", stall_cycles, 32'd6);
`endif

    // Randomised run against the model; issue only when the model says no stall.
    for (int n = 0; n < 400; n++) begin
      ex_rs = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
      fwd_rd = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
      fwd_wr = 2'($urandom);
      id_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used = 2'($urandom);
      iss_wr = 1'($urandom);
      iss_rd = 5'($urandom_range(0, 7));
      iss_lat = 3'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      iss_valid = !mStall() && ($urandom_range(0, 2) != 0);
      #1;
      chk("rand_sel", 32'(fwd_sel), 32'(mSel()));
      chk("rand_stall", 32'(stall_id), 32'(mStall()));
      chk("rand_busy", sb_busy, mBusy());
      tick();
    end
    rst = 1'b0; iss_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
